// File: rtl/nanov_spi_fetch.sv
// rtl/nanov_spi_fetch.sv - mode-0 SPI flash READ streamer feeding nanoV a serial bit stream and 32-bit words
// SCK is cpu_clk/2 generated from a phase flag, so everything lives in the single core clock domain.

module nanov_spi_fetch #(
  parameter logic [7:0] READ_CMD       = 8'h03,
  parameter int         CS_IDLE_CYCLES = 2
) (
  input  logic        cpu_clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic        stop,
  input  logic        spi_miso,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        bit_out,
  output logic        bit_valid,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_END
  } state_t;

  localparam int         END_LAST   = (CS_IDLE_CYCLES > 1) ? CS_IDLE_CYCLES - 1 : 0;
  localparam logic [7:0] END_LAST_W = END_LAST[7:0];

  state_t      state_q;
  logic        phase_q;
  logic [4:0]  bit_cnt_q;
  logic [4:0]  data_cnt_q;
  logic [31:0] shreg_q;
  logic [7:0]  end_cnt_q;

  logic [31:0] shreg_d;
  logic [4:0]  bit_cnt_d;
  logic [4:0]  data_cnt_d;
  logic [31:0] word_d;
  logic [7:0]  end_cnt_d;
  logic        abort;

  // Rotating keeps every register bit live; only the top 32 bits sent matter.
  assign shreg_d    = {shreg_q[30:0], shreg_q[31]};
  assign bit_cnt_d  = bit_cnt_q + 5'd1;
  assign data_cnt_d = data_cnt_q + 5'd1;
  assign word_d     = {word[30:0], spi_miso};
  assign end_cnt_d  = end_cnt_q + 8'd1;
  assign abort      = stop && ((state_q == S_CMD) || (state_q == S_DATA));
  assign busy       = (state_q != S_IDLE);

  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      bit_cnt_q  <= 5'd0;
      data_cnt_q <= 5'd0;
      shreg_q    <= 32'd0;
      end_cnt_q  <= 8'd0;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      word_valid <= 1'b0;
      if (abort) begin
        // A half-clocked bit is dropped: the capture branch below never runs.
        state_q    <= S_END;
        phase_q    <= 1'b0;
        bit_cnt_q  <= 5'd0;
        data_cnt_q <= 5'd0;
        end_cnt_q  <= 8'd0;
        spi_cs_n   <= 1'b1;
        spi_sck    <= 1'b0;
        spi_mosi   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !stop) begin
              shreg_q   <= {READ_CMD, addr};
              state_q   <= S_CMD;
              phase_q   <= 1'b0;
              bit_cnt_q <= 5'd0;
              spi_cs_n  <= 1'b0;
              spi_sck   <= 1'b0;
              spi_mosi  <= READ_CMD[7];
            end
          end
          S_CMD: begin
            if (!phase_q) begin
              spi_sck <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              phase_q <= 1'b0;
              if (bit_cnt_q == 5'd31) begin
                state_q    <= S_DATA;
                spi_mosi   <= 1'b0;
                bit_cnt_q  <= 5'd0;
                data_cnt_q <= 5'd0;
              end else begin
                bit_cnt_q <= bit_cnt_d;
                shreg_q   <= shreg_d;
                spi_mosi  <= shreg_q[30];
              end
            end
          end
          S_DATA: begin
            if (!phase_q) begin
              spi_sck <= 1'b1;
              phase_q <= 1'b1;
            end else begin
              spi_sck    <= 1'b0;
              phase_q    <= 1'b0;
              bit_out    <= spi_miso;
              bit_valid  <= 1'b1;
              word       <= word_d;
              data_cnt_q <= data_cnt_d;
              word_valid <= (data_cnt_q == 5'd31);
            end
          end
          S_END: begin
            if (end_cnt_q == END_LAST_W) begin
              state_q <= S_IDLE;
            end else begin
              end_cnt_q <= end_cnt_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nanov_spi_fetch.sv
// tb/tb_nanov_spi_fetch.sv - directed self-checking bench for nanov_spi_fetch with a small flash model

module tb_nanov_spi_fetch;

  logic        cpu_clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [23:0] addr;
  logic        stop;
  logic        spi_miso;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        bit_out;
  logic        bit_valid;
  logic [31:0] word;
  logic        word_valid;
  logic        busy;

  int          n_assert    = 0;
  int          n_fail      = 0;
  int          cyc         = 0;
  int          n0          = 0;
  int          bv_cnt      = 0;
  int          bv0         = 0;
  int          wv_cnt      = 0;
  int          consec_viol = 0;
  int          wv_viol     = 0;
  int          bad         = 0;
  logic        prev_bv     = 1'b0;
  logic [31:0] bv_bits     = 32'd0;

  int          rises       = 0;
  logic [31:0] mosi_sr     = 32'd0;
  logic [63:0] stream      = 64'hDEADBEEF_00000013;

  nanov_spi_fetch dut (
    .cpu_clk   (cpu_clk),
    .rstn      (rstn),
    .start     (start),
    .addr      (addr),
    .stop      (stop),
    .spi_miso  (spi_miso),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .word      (word),
    .word_valid(word_valid),
    .busy      (busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Flash model: counts completed SCK high phases while selected, captures MOSI for the
  // first 32, then presents stream bits MSB-first.
  always @(posedge cpu_clk) begin
    if (spi_cs_n !== 1'b0) begin
      rises <= 0;
    end else if (spi_sck === 1'b1) begin
      if (rises < 32) mosi_sr <= {mosi_sr[30:0], spi_mosi};
      rises <= rises + 1;
    end
  end

  assign spi_miso = (rises >= 32 && rises < 96) ? stream[95 - rises] : 1'b0;

  task automatic tick();
    @(negedge cpu_clk);
    cyc++;
    if (bit_valid === 1'b1) begin
      bv_cnt++;
      bv_bits = {bv_bits[30:0], bit_out};
      if (prev_bv === 1'b1) consec_viol++;
    end
    if (word_valid === 1'b1) begin
      wv_cnt++;
      if (bit_valid !== 1'b1) wv_viol++;
    end
    prev_bv = bit_valid;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs_n"}, {31'd0, spi_cs_n}, 32'd1);
    chk({tag, "_sck"}, {31'd0, spi_sck}, 32'd0);
    chk({tag, "_mosi"}, {31'd0, spi_mosi}, 32'd0);
    chk({tag, "_bit_out"}, {31'd0, bit_out}, 32'd0);
    chk({tag, "_bit_valid"}, {31'd0, bit_valid}, 32'd0);
    chk({tag, "_word"}, word, 32'd0);
    chk({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b1;
    stop  = 1'b0;
    addr  = 24'h123456;
    tickn(3);
    chk_reset("rst");

    rstn  = 1'b1;
    start = 1'b0;
    tickn(2);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cs_n", {31'd0, spi_cs_n}, 32'd1);

    // Transfer 1: addr 123456, full two words
    start = 1'b1;
    tick();
    start = 1'b0;
    n0 = cyc - 1;
    chk("t1_cs_n", {31'd0, spi_cs_n}, 32'd0);
    chk("t1_sck", {31'd0, spi_sck}, 32'd0);
    chk("t1_mosi_first", {31'd0, spi_mosi}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    bad = 0;
    for (int off = 2; off <= 64; off++) begin
      tick();
      if (spi_sck !== ((off % 2) == 0) || spi_cs_n !== 1'b0) bad++;
    end
    chk("t1_cmd_sck_pattern", bad, 32'd0);
    run_to(n0 + 66);
    chk("t1_cmd_bits", mosi_sr, 32'h03123456);
    chk("t1_rises_before_data", rises, 32'd32);
    chk("t1_no_early_bv", bv_cnt, 32'd0);
    tick();
    chk("t1_first_bv", {31'd0, bit_valid}, 32'd1);
    chk("t1_first_bit", {31'd0, bit_out}, 32'd1);
    run_to(n0 + 128);
    chk("t1_wv_before", {31'd0, word_valid}, 32'd0);
    tick();
    chk("t1_wv1", {31'd0, word_valid}, 32'd1);
    chk("t1_word1", word, 32'hDEADBEEF);
    chk("t1_bits1", bv_bits, 32'hDEADBEEF);
    chk("t1_bv_cnt1", bv_cnt, 32'd32);
    run_to(n0 + 193);
    chk("t1_wv2", {31'd0, word_valid}, 32'd1);
    chk("t1_word2", word, 32'h00000013);
    chk("t1_bits2", bv_bits, 32'h00000013);
    chk("t1_wv_cnt", wv_cnt, 32'd2);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t1_stop_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("t1_stop_sck", {31'd0, spi_sck}, 32'd0);
    chk("t1_stop_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_end_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    chk("t1_word_hold", word, 32'h00000013);

    // Transfer 2: addr ABCDEF, stop during the high phase of data bit 5
    addr  = 24'hABCDEF;
    start = 1'b1;
    tick();
    start = 1'b0;
    n0  = cyc - 1;
    bv0 = bv_cnt;
    run_to(n0 + 66);
    chk("t2_cmd_bits", mosi_sr, 32'h03ABCDEF);
    run_to(n0 + 76);
    chk("t2_bit5_high", {31'd0, spi_sck}, 32'd1);
    stop = 1'b1;
    tick();
    stop  = 1'b0;
    chk("t2_no_bv_bit5", {31'd0, bit_valid}, 32'd0);
    chk("t2_stop_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("t2_stop_sck", {31'd0, spi_sck}, 32'd0);
    chk("t2_bv_count", bv_cnt - bv0, 32'd5);
    chk("t2_bits", {27'd0, bv_bits[4:0]}, 32'h0000001B);
    chk("t2_word_partial", word, 32'h0000027B);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_end_busy", {31'd0, busy}, 32'd1);
    chk("t2_end_cs_n", {31'd0, spi_cs_n}, 32'd1);
    tick();
    chk("t2_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t2_start_in_end_ignored", {31'd0, busy}, 32'd0);

    // Transfer 3: restart with a new address
    addr  = 24'h654321;
    start = 1'b1;
    tick();
    start = 1'b0;
    n0 = cyc - 1;
    run_to(n0 + 66);
    chk("t3_cmd_bits", mosi_sr, 32'h03654321);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tickn(2);
    chk("t3_idle_busy", {31'd0, busy}, 32'd0);

    // start and stop together in IDLE, then stop alone in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", {31'd0, busy}, 32'd0);
    chk("ss_cs_n", {31'd0, spi_cs_n}, 32'd1);
    tick();
    chk("ss_busy_late", {31'd0, busy}, 32'd0);
    stop = 1'b1;
    tickn(2);
    stop = 1'b0;
    chk("idle_stop_word", word, 32'h0000027B);
    chk("idle_stop_busy", {31'd0, busy}, 32'd0);

    // Reset pulsed mid-CMD
    addr  = 24'h000001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tickn(10);
    chk("mr_in_cmd", {31'd0, spi_cs_n}, 32'd0);
    rstn = 1'b0;
    tick();
    chk_reset("mr");
    rstn = 1'b1;
    tick();
    addr  = 24'hFFFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    n0 = cyc - 1;
    chk("mr_restart_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("mr_restart_busy", {31'd0, busy}, 32'd1);
    run_to(n0 + 66);
    chk("mr_cmd_bits", mosi_sr, 32'h03FFFFFF);
    chk("mr_rises", rises, 32'd32);

    chk("bv_never_consecutive", consec_viol, 32'd0);
    chk("wv_implies_bv", wv_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
